uart_tx_arbiter: RTL and testbench

- Shares the transmit side of the uart between N_REQ byte producers.
- Round-robin arbitration with optional burst locking, so a multi-byte message from one requester is not interleaved with bytes from another.
- Sequences the uart load handshake (ld_tx_data / tx_empty) and drives tx_enable.
- Sits between the system-side producers and the uart tx port; same clock domain as the uart txclk.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 157 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Producer word handshake and uart load port for uart_tx_arbiter.
// The arbiter connects through the slave modport; producers and the uart drive the master side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    ld_tx_data;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_empty;

    modport master (
        output req_valid, req_data, req_last, tx_empty,
        input  req_ready, ld_tx_data, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_empty,
        output req_ready, ld_tx_data, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart transmit port between N_REQ byte producers,
// with burst locking so a multi-word message is never interleaved with another.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int ACK_TO    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    uart_tx_arbiter_if.slave         bus,
    output logic                     tx_enable,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     err_timeout,
    input  logic                     err_clr
);
    localparam int ID_W = $clog2(N_REQ);
    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam int AC_W = $clog2(ACK_TO + 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, grant_d;
    logic              lock_q, lock_d, last_q, last_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic [AC_W-1:0]   ack_q, ack_d;
    logic              ld_d, err_d, busy_d, tx_enable_d;
    logic [N_REQ-1:0]  ready_d;
    logic [DATA_W-1:0] tx_data_d;

    logic [DATA_W-1:0] word [N_REQ];
    logic [N_REQ-1:0]  elig;
    logic              pick_ok, done, err_set;
    logic [ID_W-1:0]   pick, idx;

    always_comb begin
        for (int unsigned j = 0; j < N_REQ; j++)
            word[j] = bus.req_data[j*DATA_W +: DATA_W];
    end

    // While locked only the current owner is eligible; scan upward from rr_ptr with wrap.
    always_comb begin
        elig    = lock_q ? (bus.req_valid & (N_REQ'(1) << grant_id)) : bus.req_valid;
        pick_ok = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(rr_ptr_q) + k) % N_REQ);
            if (!pick_ok && elig[idx]) begin
                pick_ok = 1'b1;
                pick    = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_id;
        lock_d    = lock_q;
        last_d    = last_q;
        burst_d   = burst_q;
        ack_d     = ack_q;
        ld_d      = 1'b0;
        ready_d   = '0;
        tx_data_d = bus.tx_data;
        done      = 1'b0;
        err_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!en) begin
                    lock_d  = 1'b0;
                    burst_d = '0;
                end
                if (en && bus.tx_empty && pick_ok) begin
                    state_d       = LOAD;
                    grant_d       = pick;
                    tx_data_d     = word[pick];
                    last_d        = bus.req_last[pick];
                    ld_d          = 1'b1;
                    ready_d[pick] = 1'b1;
                end
            end
            LOAD: begin
                state_d = WAIT_ACK;
                ack_d   = '0;
            end
            WAIT_ACK: begin
                if (!bus.tx_empty) begin
                    state_d = WAIT_DONE;
                end else if (ack_q == AC_W'(ACK_TO - 1)) begin
                    err_set = 1'b1;
                    done    = 1'b1;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.tx_empty) done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Word completion: release the lock on a last word or a full burst.
        if (done) begin
            state_d = IDLE;
            if (last_q || burst_q == BC_W'(MAX_BURST - 1)) begin
                lock_d   = 1'b0;
                burst_d  = '0;
                rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end else begin
                lock_d  = 1'b1;
                burst_d = burst_q + 1'b1;
            end
        end

        err_d       = err_set ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
        busy_d      = (state_d != IDLE);
        tx_enable_d = en | (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            lock_q         <= 1'b0;
            last_q         <= 1'b0;
            burst_q        <= '0;
            ack_q          <= '0;
            grant_id       <= '0;
            bus.ld_tx_data <= 1'b0;
            bus.req_ready  <= '0;
            bus.tx_data    <= '0;
            tx_enable      <= 1'b0;
            busy           <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            lock_q         <= lock_d;
            last_q         <= last_d;
            burst_q        <= burst_d;
            ack_q          <= ack_d;
            grant_id       <= grant_d;
            bus.ld_tx_data <= ld_d;
            bus.req_ready  <= ready_d;
            bus.tx_data    <= tx_data_d;
            tx_enable      <= tx_enable_d;
            busy           <= busy_d;
            err_timeout    <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed multi-cycle
// sequences, and randomized message traffic against a queue-level arbitration model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int TO = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic       tx_enable, busy, err_timeout;
    logic [1:0] grant_id;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB), .ACK_TO(TO)) dut (
        .clk(clk), .reset(reset), .en(en), .bus(bus), .tx_enable(tx_enable),
        .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    int tests = 0;
    int fails = 0;

    // Producer word queues: bit 8 is the last flag.
    logic [8:0] pmem [N][128];
    int         phead [N];
    int         ptail [N];

    // Uart model: tx_empty falls u_wait steps after a load and stays low u_low steps.
    int   u_wait, u_low, u_delay;
    logic u_pend, u_te, u_stuck, u_force_low;

    logic       ld_seen, prev_ld;
    int         n_obs, n_exp;
    int         obs_g [256];
    logic [7:0] obs_d [256];
    int         exp_g [256];
    logic [7:0] exp_d [256];

    typedef struct {
        logic       en;
        logic       te_low;
        logic [3:0] mask;
        logic [7:0] base;
        logic       exp_fire;
        logic [1:0] exp_g;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name, input int budget);
        tests++;
        fails++;
        $display("FAIL %s: condition not reached within %0d cycles", name, budget);
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        pmem[r][ptail[r]] = {l, d};
        ptail[r]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) phead[i] = ptail[i];
    endtask

    function automatic bit words_left();
        for (int i = 0; i < N; i++) if (phead[i] < ptail[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        logic [N-1:0]   v, l;
        logic [N*W-1:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (phead[i] < ptail[i]) begin
                v[i]         = 1'b1;
                l[i]         = pmem[i][phead[i]][8];
                d[i*W +: W]  = pmem[i][phead[i]][7:0];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
        bus.tx_empty  = u_force_low ? 1'b0 : u_te;
    endtask

    task automatic step();
        logic [N-1:0] oh;
        int           g;
        @(posedge clk);
        #1;
        ld_seen = bus.ld_tx_data;
        if (ld_seen) begin
            g  = int'(grant_id);
            oh = N'(1) << g;
            check("ld_single_pulse", 32'(prev_ld), 32'(0));
            check("ready_onehot", 32'(bus.req_ready), 32'(oh));
            if (phead[g] < ptail[g]) begin
                check("tx_data", 32'(bus.tx_data), 32'(pmem[g][phead[g]][7:0]));
                phead[g]++;
            end else begin
                tests++;
                fails++;
                $display("FAIL grant_without_word: requester %0d granted with nothing queued", g);
            end
            if (n_obs < 256) begin
                obs_g[n_obs] = g;
                obs_d[n_obs] = bus.tx_data;
                n_obs++;
            end
            if (!u_stuck) begin
                u_pend = 1'b1;
                u_wait = (u_delay != 0) ? u_delay : int'($urandom_range(1, 3));
            end
        end else begin
            check("ready_without_load", 32'(bus.req_ready), 32'(0));
            if (u_pend) begin
                u_wait--;
                if (u_wait == 0) begin
                    u_pend = 1'b0;
                    u_te   = 1'b0;
                    u_low  = int'($urandom_range(1, 3));
                end
            end else if (!u_te) begin
                u_low--;
                if (u_low == 0) u_te = 1'b1;
            end
        end
        prev_ld = ld_seen;
        drive();
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        en          = 1'b0;
        err_clr     = 1'b0;
        u_stuck     = 1'b0;
        u_force_low = 1'b0;
        u_pend      = 1'b0;
        u_te        = 1'b1;
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        n_obs   = 0;
        prev_ld = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ld_tx_data", 32'(bus.ld_tx_data), 32'(0));
        check("rst_tx_data", 32'(bus.tx_data), 32'(0));
        check("rst_tx_enable", 32'(tx_enable), 32'(0));
        check("rst_req_ready", 32'(bus.req_ready), 32'(0));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_err_timeout", 32'(err_timeout), 32'(0));
        reset = 1'b1;
    endtask

    task automatic wait_obs(input int n, input int budget, input string name);
        int k = 0;
        while (n_obs < n && k < budget) begin
            step();
            k++;
        end
        if (n_obs < n) fail_bound(name, budget);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int k = 0;
        while ((busy || u_pend || !u_te) && k < budget) begin
            step();
            k++;
        end
        if (busy || u_pend || !u_te) fail_bound(name, budget);
    endtask

    task automatic set_exp(input int k, input int g, input logic [7:0] d);
        exp_g[k] = g;
        exp_d[k] = d;
    endtask

    task automatic cmp_seq(input string name, input int n);
        check({name, "_count"}, 32'(n_obs), 32'(n));
        for (int k = 0; k < n && k < n_obs; k++) begin
            check({name, "_grant"}, 32'(obs_g[k]), 32'(exp_g[k]));
            check({name, "_data"}, 32'(obs_d[k]), 32'(exp_d[k]));
        end
    endtask

    // Message-level arbitration: serve the lock owner, else the first queued
    // requester at or after the pointer; release on last word or full burst.
    task automatic ref_model();
        int h [N];
        int ptr, owner, cnt, g, c;
        for (int i = 0; i < N; i++) h[i] = phead[i];
        ptr = 0; owner = -1; cnt = 0; n_exp = 0;
        for (int s = 0; s < 256; s++) begin
            g = -1;
            if (owner >= 0) begin
                if (h[owner] < ptail[owner]) g = owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    c = (ptr + k) % N;
                    if (g < 0 && h[c] < ptail[c]) g = c;
                end
            end
            if (g < 0) break;
            set_exp(n_exp, g, pmem[g][h[g]][7:0]);
            n_exp++;
            cnt++;
            if (pmem[g][h[g]][8] || cnt == MB) begin
                owner = -1;
                cnt   = 0;
                ptr   = (g + 1) % N;
            end else begin
                owner = g;
            end
            h[g]++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       fired;
        logic [1:0] fg;
        logic [7:0] fd;
        int         k, bad;

        u_delay = 2;
        do_reset();

        // en, tx_empty held low, valid mask, data base, fire?, expected grant
        tbl[0] = '{1'b1, 1'b0, 4'b0001, 8'h55, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 4'b1111, 8'h10, 1'b1, 2'd1};
        tbl[2] = '{1'b1, 1'b0, 4'b0011, 8'h20, 1'b1, 2'd0};
        tbl[3] = '{1'b0, 1'b0, 4'b1111, 8'h30, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 1'b1, 4'b0100, 8'h38, 1'b0, 2'd0};
        tbl[5] = '{1'b1, 1'b0, 4'b1000, 8'h40, 1'b1, 2'd3};
        tbl[6] = '{1'b1, 1'b0, 4'b1010, 8'h60, 1'b1, 2'd1};
        tbl[7] = '{1'b1, 1'b0, 4'b0000, 8'h68, 1'b0, 2'd0};
        tbl[8] = '{1'b1, 1'b0, 4'b0101, 8'h70, 1'b1, 2'd2};
        tbl[9] = '{1'b1, 1'b0, 4'b0001, 8'h80, 1'b1, 2'd0};

        for (int r = 0; r < 10; r++) begin
            clear_q();
            for (int i = 0; i < N; i++)
                if (tbl[r].mask[i]) push(i, tbl[r].base + 8'(i), 1'b1);
            en          = tbl[r].en;
            u_force_low = tbl[r].te_low;
            drive();
            fired = 1'b0; fg = '0; fd = '0;
            for (int s = 0; s < 5; s++) begin
                step();
                if (ld_seen && !fired) begin
                    fired = 1'b1;
                    fg    = grant_id;
                    fd    = bus.tx_data;
                    clear_q();
                    drive();
                end
            end
            check("row_fire", 32'(fired), 32'(tbl[r].exp_fire));
            if (tbl[r].exp_fire) begin
                check("row_grant", 32'(fg), 32'(tbl[r].exp_g));
                check("row_data", 32'(fd), 32'(tbl[r].base + 8'(tbl[r].exp_g)));
            end
            en = 1'b1; u_force_low = 1'b0;
            clear_q();
            drive();
            wait_idle(40, "row_idle");
        end

        // Round robin with one requester queuing a second word.
        do_reset();
        en = 1'b1;
        push(0, 8'h10, 1'b1); push(0, 8'h10, 1'b1);
        push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        drive();
        wait_obs(5, 200, "rr_loads");
        wait_idle(40, "rr_idle");
        set_exp(0, 0, 8'h10); set_exp(1, 1, 8'h11); set_exp(2, 2, 8'h12);
        set_exp(3, 3, 8'h13); set_exp(4, 0, 8'h10);
        cmp_seq("rr", 5);

        // Burst lock holds req1 off until req0's last word.
        do_reset();
        en = 1'b1;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(1, 8'hB0, 1'b1);
        drive();
        wait_obs(4, 200, "lock_loads");
        wait_idle(40, "lock_idle");
        set_exp(0, 0, 8'hA0); set_exp(1, 0, 8'hA1); set_exp(2, 0, 8'hA2); set_exp(3, 1, 8'hB0);
        cmp_seq("lock", 4);

        // Lock forcibly released after MAX_BURST words.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 4; i++) push(0, 8'hC0 + 8'(i), 1'b0);
        push(0, 8'hC4, 1'b1);
        push(2, 8'hD0, 1'b1);
        drive();
        wait_obs(6, 300, "burst_loads");
        wait_idle(40, "burst_idle");
        for (int i = 0; i < 4; i++) set_exp(i, 0, 8'hC0 + 8'(i));
        set_exp(4, 2, 8'hD0); set_exp(5, 0, 8'hC4);
        cmp_seq("burst", 6);

        // Owner idle while locked: nobody else served until en drops.
        do_reset();
        en = 1'b1;
        push(0, 8'hE0, 1'b0);
        push(1, 8'hF0, 1'b1);
        drive();
        wait_obs(1, 50, "stall_first");
        repeat (20) step();
        check("stall_no_grant", 32'(n_obs), 32'(1));
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        wait_obs(2, 50, "stall_release");
        wait_idle(40, "stall_idle");
        set_exp(0, 0, 8'hE0); set_exp(1, 1, 8'hF0);
        cmp_seq("stall", 2);

        // en dropped during the load cycle: word completes, then no grants.
        do_reset();
        en = 1'b1;
        push(0, 8'h77, 1'b1);
        push(1, 8'h88, 1'b1);
        drive();
        wait_obs(1, 50, "endrop_load");
        en = 1'b0;
        k = 0; bad = 0;
        while (busy && k < 40) begin
            if (tx_enable !== 1'b1) bad++;
            step();
            k++;
        end
        check("endrop_tx_en_busy", 32'(bad), 32'(0));
        check("endrop_idle", 32'(busy), 32'(0));
        check("endrop_tx_en_at_idle", 32'(tx_enable), 32'(1));
        step();
        check("endrop_tx_en_off", 32'(tx_enable), 32'(0));
        repeat (10) step();
        check("endrop_no_grant", 32'(n_obs), 32'(1));

        // Timeout with tx_empty never falling, then clear.
        do_reset();
        u_stuck = 1'b1;
        en = 1'b1;
        push(0, 8'h99, 1'b1);
        drive();
        wait_obs(1, 50, "to_load");
        k = 0;
        while (!err_timeout && k < 80) begin
            step();
            k++;
        end
        check("to_latency", 32'(k), 32'(TO + 1));
        check("to_back_idle", 32'(busy), 32'(0));
        repeat (5) step();
        check("to_sticky", 32'(err_timeout), 32'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("to_cleared", 32'(err_timeout), 32'(0));

        // Set beats a simultaneous clear.
        err_clr = 1'b1;
        push(0, 8'h9A, 1'b1);
        drive();
        wait_obs(2, 50, "to2_load");
        k = 0;
        while (!err_timeout && k < 80) begin
            step();
            k++;
        end
        check("to_set_wins", 32'(err_timeout), 32'(1));
        check("to2_latency", 32'(k), 32'(TO + 1));
        step();
        check("to_clr_held", 32'(err_timeout), 32'(0));
        err_clr = 1'b0;
        u_stuck = 1'b0;

        // Reset in the middle of a word takes effect without a clock edge.
        do_reset();
        en = 1'b1;
        push(2, 8'h5A, 1'b1);
        drive();
        wait_obs(1, 50, "mid_load");
        check("mid_grant", 32'(grant_id), 32'(2));
        step();
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ld", 32'(bus.ld_tx_data), 32'(0));
        check("mid_rst_ready", 32'(bus.req_ready), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_grant", 32'(grant_id), 32'(0));
        check("mid_rst_tx_data", 32'(bus.tx_data), 32'(0));
        check("mid_rst_tx_en", 32'(tx_enable), 32'(0));

        // Randomized message traffic against the queue-level model.
        u_delay = 0;
        for (int rnd = 0; rnd < 4; rnd++) begin
            do_reset();
            en = 1'b1;
            for (int i = 0; i < N; i++) begin
                int m, len;
                m = int'($urandom_range(0, 3));
                for (int j = 0; j < m; j++) begin
                    len = int'($urandom_range(1, 6));
                    for (int w = 0; w < len; w++) push(i, 8'($urandom), w == len - 1);
                end
            end
            ref_model();
            drive();
            k = 0;
            while ((words_left() || busy || u_pend || !u_te) && k < 3000) begin
                step();
                k++;
            end
            if (words_left() || busy) fail_bound("rand_drain", 3000);
            cmp_seq("rand", n_exp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
